// File: rtl/bomb_pool.sv
// Bomb slot pool: per-player placement, fuse/blast timing on a shared game tick,
// cross-shaped explosion coverage and one-hop-per-cycle chain reactions.

module bomb_slot #(
  parameter int FUSE_BASE   = 2,
  parameter int BLAST_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_tx,
  input  logic [3:0] ld_ty,
  input  logic [3:0] ld_stats,
  input  logic       chain,
  output logic [1:0] st,
  output logic [3:0] tx,
  output logic [3:0] ty,
  output logic [1:0] rad,
  output logic       died
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FUSE  = 2'd1;
  localparam logic [1:0] BLAST = 2'd2;

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE; tx <= '0; ty <= '0; rad <= '0; cnt <= '0; died <= 1'b0;
    end else if (clear) begin
      st <= IDLE; tx <= '0; ty <= '0; rad <= '0; cnt <= '0; died <= 1'b0;
    end else begin
      died <= 1'b0;
      case (st)
        IDLE: begin
          if (load) begin
            st  <= FUSE;
            tx  <= ld_tx;
            ty  <= ld_ty;
            rad <= ld_stats[3:2];
            // potency only lengthens the fuse, so it lives on in the counter
            cnt <= 3'(FUSE_BASE) + {1'b0, ld_stats[1:0]};
          end else begin
            tx <= '0; ty <= '0; rad <= '0; cnt <= '0;
          end
        end
        FUSE: begin
          if (chain) begin
            st <= BLAST; cnt <= 3'(BLAST_TICKS);
          end else if (tick) begin
            if (cnt <= 3'd1) begin
              st <= BLAST; cnt <= 3'(BLAST_TICKS);
            end else cnt <= cnt - 3'd1;
          end
        end
        BLAST: begin
          if (tick) begin
            if (cnt <= 3'd1) begin
              st <= IDLE; cnt <= '0; died <= 1'b1;
            end else cnt <= cnt - 3'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module bomb_pool #(
  parameter int PLAYERS          = 2,
  parameter int BOMBS_PER_PLAYER = 3,
  parameter int GRID             = 11,
  parameter int TICK_DIV         = 50000000,
  parameter int FUSE_BASE        = 2,
  parameter int BLAST_TICKS      = 2,
  localparam int N = PLAYERS * BOMBS_PER_PLAYER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [PLAYERS-1:0]     place,
  input  logic [4*PLAYERS-1:0]   place_tX,
  input  logic [4*PLAYERS-1:0]   place_tY,
  input  logic [4*PLAYERS-1:0]   stats,
  input  logic [3:0]             bomb_id,
  output logic [10:0]            bomb_info,
  input  logic [3:0]             qX,
  input  logic [3:0]             qY,
  output logic                   has_explosion,
  output logic [N-1:0]           died,
  output logic [PLAYERS-1:0]     place_ack,
  output logic [PLAYERS-1:0]     place_nack,
  output logic [3*PLAYERS-1:0]   active_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FUSE  = 2'd1;
  localparam logic [1:0] BLAST = 2'd2;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]             tick_cnt;
  logic                      tick;
  logic [PLAYERS-1:0]        place_q, rise, acc, rej;
  logic [PLAYERS-1:0][3:0]   px, py;
  logic [N-1:0]              load, chain;
  logic [N-1:0][1:0]         st, rad;
  logic [N-1:0][3:0]         tx, ty;
  logic                      ok, found;

  assign px   = place_tX;
  assign py   = place_tY;
  assign tick = (tick_cnt == '0);
  assign rise = place & ~place_q;

  // Cross-shaped reach, clipped to the stage in 5-bit space so t+reach cannot wrap.
  function automatic logic covers(input logic [3:0] cx, cy, input logic [1:0] r,
                                  input logic [3:0] qx, qy);
    logic [4:0] reach, xlo, xhi, ylo, yhi;
    reach = {3'b0, r} + 5'd1;
    xlo = ({1'b0, cx} >= reach) ? {1'b0, cx} - reach : 5'd0;
    ylo = ({1'b0, cy} >= reach) ? {1'b0, cy} - reach : 5'd0;
    xhi = ({1'b0, cx} + reach > 5'(GRID - 1)) ? 5'(GRID - 1) : {1'b0, cx} + reach;
    yhi = ({1'b0, cy} + reach > 5'(GRID - 1)) ? 5'(GRID - 1) : {1'b0, cy} + reach;
    covers = ((qy == cy) && ({1'b0, qx} >= xlo) && ({1'b0, qx} <= xhi)) ||
             ((qx == cx) && ({1'b0, qy} >= ylo) && ({1'b0, qy} <= yhi));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= TW'(TICK_DIV - 1);
      place_q  <= place;
      place_ack <= '0; place_nack <= '0;
    end else if (clear) begin
      tick_cnt <= TW'(TICK_DIV - 1);
      place_q  <= place;
      place_ack <= '0; place_nack <= '0;
    end else begin
      tick_cnt  <= tick ? TW'(TICK_DIV - 1) : tick_cnt - TW'(1);
      place_q   <= place;
      place_ack <= acc;
      place_nack <= rej;
    end
  end

  // Lower player index wins a same-tile collision because acc[q<p] is already settled.
  always_comb begin
    load = '0; acc = '0; rej = '0; ok = 1'b0; found = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      ok = rise[p] && ({1'b0, px[p]} < 5'(GRID)) && ({1'b0, py[p]} < 5'(GRID));
      for (int j = 0; j < N; j++)
        if (st[j] != IDLE && tx[j] == px[p] && ty[j] == py[p]) ok = 1'b0;
      for (int q = 0; q < p; q++)
        if (acc[q] && px[q] == px[p] && py[q] == py[p]) ok = 1'b0;
      found = 1'b0;
      for (int k = 0; k < BOMBS_PER_PLAYER; k++)
        if (!found && st[p*BOMBS_PER_PLAYER + k] == IDLE) begin
          found = 1'b1;
          if (ok) load[p*BOMBS_PER_PLAYER + k] = 1'b1;
        end
      acc[p] = ok && found;
      rej[p] = rise[p] && !(ok && found);
    end
  end

  always_comb begin
    chain = '0; has_explosion = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (st[i] == BLAST && covers(tx[i], ty[i], rad[i], qX, qY)) has_explosion = 1'b1;
      for (int j = 0; j < N; j++)
        if (st[i] == FUSE && st[j] == BLAST && covers(tx[j], ty[j], rad[j], tx[i], ty[i]))
          chain[i] = 1'b1;
    end
  end

  always_comb begin
    bomb_info = '0;
    for (int i = 0; i < N; i++)
      if (bomb_id == 4'(i)) bomb_info = {ty[i], tx[i], rad[i], st[i] == FUSE};
  end

  always_comb begin
    active_count = '0;
    for (int p = 0; p < PLAYERS; p++)
      for (int k = 0; k < BOMBS_PER_PLAYER; k++)
        active_count[3*p +: 3] = active_count[3*p +: 3] +
                                 3'(st[p*BOMBS_PER_PLAYER + k] != IDLE);
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    localparam int P = i / BOMBS_PER_PLAYER;
    bomb_slot #(.FUSE_BASE(FUSE_BASE), .BLAST_TICKS(BLAST_TICKS)) u_slot (
      .clk(clk), .reset(reset), .clear(clear), .tick(tick), .load(load[i]),
      .ld_tx(px[P]), .ld_ty(py[P]), .ld_stats(stats[4*P +: 4]), .chain(chain[i]),
      .st(st[i]), .tx(tx[i]), .ty(ty[i]), .rad(rad[i]), .died(died[i])
    );
  end
endmodule

// File: doc/bomb_pool.md
BOMB_POOL -- requirements
Module: bomb_pool

Interface
REQ-001 Parameter PLAYERS, default 2, number of players.
REQ-002 Parameter BOMBS_PER_PLAYER, default 3, slots per player; total slots N = PLAYERS*BOMBS_PER_PLAYER, N <= 16.
REQ-003 Parameter GRID, default 11, stage is GRID x GRID tiles, coordinates 0..GRID-1.
REQ-004 Parameter TICK_DIV, default 50000000, clk cycles per game tick.
REQ-005 Parameter FUSE_BASE, default 2, minimum fuse length in ticks.
REQ-006 Parameter BLAST_TICKS, default 2, explosion duration in ticks.
REQ-007 clk  in  1  50 MHz system clock.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 clear  in  1  synchronous stage clear, same effect as reset on the next clk edge.
REQ-010 place  in  PLAYERS  per-player placement request, level signal, rising edge acts.
REQ-011 place_tX, place_tY  in  4*PLAYERS each  per-player tile coordinate of the request.
REQ-012 stats  in  4*PLAYERS  per-player {radius[1:0], potency[1:0]}.
REQ-013 bomb_id  in  4  slot index for the drawing lookup.
REQ-014 bomb_info  out  11  {tY[3:0], tX[3:0], radius[1:0], visible}; visible = slot in FUSE.
REQ-015 qX, qY  in  4 each  tile coordinate for the explosion lookup.
REQ-016 has_explosion  out  1  combinational; high if any BLAST slot covers (qX, qY).
REQ-017 died  out  N  one-cycle pulse per slot on BLAST -> IDLE; its coordinates stay readable via bomb_info in the pulse cycle.
REQ-018 place_ack, place_nack  out  PLAYERS each  one-cycle pulse per accepted / rejected request.
REQ-019 active_count  out  3*PLAYERS  per player, number of slots not IDLE.

Function
REQ-020 Tick generator: down-counter reloads TICK_DIV-1; tick is high for one cycle at count 0; it runs freely, so the first tick after placement may be partial.
REQ-021 Slot p*BOMBS_PER_PLAYER+k belongs to player p; each slot has states IDLE, FUSE and BLAST, plus stored tX, tY, radius, potency and a 3-bit tick counter.
REQ-022 Rising edge of place[p] (registered edge detect) is accepted only if:
  - player p has an IDLE slot;
  - no FUSE/BLAST slot holds the same tile;
  - both coordinates are < GRID.
REQ-023 Acceptance:
  - the lowest-index IDLE slot of player p enters FUSE on the next edge;
  - it latches coordinates and stats;
  - counter = FUSE_BASE + potency;
  - place_ack[p] pulses in the same cycle.
  Otherwise place_nack[p] pulses and no state changes.
REQ-024 Simultaneous requests for the same tile: the lowest player index is accepted and the others are nacked.
REQ-025 FUSE: counter decrements on each tick; on a tick with counter == 1 the slot enters BLAST with counter = BLAST_TICKS.
REQ-026 BLAST: counter decrements on each tick; on a tick with counter == 1 the slot enters IDLE, died[slot] pulses, and stored fields are zeroed the cycle after.
REQ-027 Coverage: a BLAST slot covers its own tile and the tiles up to radius+1 steps in each of the four axis directions.
  - Clipped at 0 and GRID-1, no wrap-around.
  - Arithmetic uses 5-bit unsigned with an explicit bounds check.
  - No wall occlusion; the stage module owns terrain.
REQ-028 Chain reaction: a FUSE slot whose tile is covered by any BLAST slot enters BLAST on the next clk edge, independent of tick, with counter = BLAST_TICKS.
  - Chains propagate one hop per clk cycle.
REQ-029 Chain takes priority over a fuse tick in the same cycle; the resulting counter is BLAST_TICKS.
REQ-030 A placement request in the same cycle a slot frees does not reuse that slot; the request sees pre-edge state.
REQ-031 bomb_id >= N returns bomb_info = 0.
REQ-032 Several slots may finish in the same cycle; each raises its own died bit, with no serialisation.

Reset
REQ-033 Async reset, or clear at the next edge:
  - all slots IDLE with zero fields;
  - tick counter = TICK_DIV-1;
  - edge-detect registers = current place value, so no spurious accept;
  - died, place_ack and place_nack = 0;
  - active_count = 0;
  - has_explosion = 0.
REQ-034 Reset asserted mid-FUSE or mid-BLAST drops the slot to IDLE with no died pulse.

Verification (TICK_DIV=4, FUSE_BASE=2, BLAST_TICKS=2)
REQ-035 P0 places at (3,3), potency 1:
  - ack next cycle;
  - visible for 3 ticks;
  - has_explosion at (3,3) for 2 ticks;
  - died[0] pulses once.
REQ-036 P0 places 4 bombs at distinct tiles: 3 acks, then a nack on the 4th; active_count[0] = 3.
REQ-037 P0 bomb at (2,5) radius 0 and P1 bomb at (4,5) radius 1 placed later:
  - P0 blasts first;
  - (4,5) is not covered by P0 (distance 2 > radius+1 = 1), so no chain;
  - repeated with P1 at (3,5): P1 enters BLAST 1 cycle after P0 blasts.
REQ-038 Same-tile simultaneous place by P0 and P1 at (1,1): ack[0], nack[1].
REQ-039 Radius 3 bomb at (0,10): coverage (0..4,10) and (0,6..10); query (0,0) low; no wrap.
REQ-040 Reset pulse mid-BLAST: has_explosion drops immediately, died stays 0, and a new placement is accepted afterwards.
